// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory port arbiter:
//   - arb_state_t : port-1 lock FSM states (IDLE, LOCK1)
//   - PORT_CPU / PORT_DMA : port identifiers (core load/store path, loader/DMA master)
//   - in_range()  : byte-address limit check against the memory depth
package dmem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      LOCK1 = 1'b1
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   // Legal byte addresses are 0 .. 4*depth_words-1. Arguments are widened to
   // 64 bits so the limit itself never overflows the address width.
   function automatic logic in_range(input logic [63:0] byte_addr,
                                     input logic [63:0] depth_words);
      return byte_addr < (depth_words << 2);
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Combinational winner selection for the two memory requesters.
//   Ports:
//     req         in  2  qualified requests {port1, port0}
//     lock_active in  1  port 1 currently holds a lock
//     starve_sat  in  1  port 1 has been denied MAX_WAIT cycles in a row
//     cpu_first   in  1  a lock just ran to its beat limit; port 0 takes the next tie
//     last_winner in  1  port that won the most recent grant
//     gnt         out 2  one-hot grant {port1, port0}, zero when nobody requests
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int CPU_PRIO = 1
) (
   input  logic [1:0] req,
   input  logic       lock_active,
   input  logic       starve_sat,
   input  logic       cpu_first,
   input  logic       last_winner,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (lock_active && req[1]) begin
         gnt = 2'b10;
      end else if (req == 2'b01) begin
         gnt = 2'b01;
      end else if (req == 2'b10) begin
         gnt = 2'b10;
      end else if (req == 2'b11) begin
         if (cpu_first) begin
            // Lock ran to its limit: give the core its turn before anything else.
            gnt = 2'b01;
         end else if (CPU_PRIO != 0) begin
            gnt = starve_sat ? 2'b10 : 2'b01;
         end else begin
            gnt = (last_winner == PORT_CPU) ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port word memory (async read, sync write) between the
//   core load/store path (port 0) and a loader/DMA master (port 1). Grants are
//   combinational so the core can stall in the cycle it loses arbitration.
//   Ports:
//     clk, rst                 clock (rising edge), async active-low reset
//     m0_* / m1_*              requester ports: req, we, addr, wdata in;
//                              gnt, rdata out; m0_stall out; m1_lock in
//     mem_we/addr/wdata        memory write/address/data, driven by the winner
//     mem_rdata                memory read data
//     err/err_port/err_addr    registered out-of-range report (err is a pulse)
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int CPU_PRIO    = 1,
   parameter int MAX_WAIT    = 4,
   parameter int LOCK_MAX    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_stall,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m1_lock,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err,
   output logic              err_port,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);

   arb_state_t        state_reg, state_next;
   logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;
   logic [LW-1:0]     lock_cnt_reg, lock_cnt_next;
   logic [LW-1:0]     beat_cnt;
   logic              last_winner_reg, last_winner_next;
   logic              cpu_first_reg, cpu_first_next;
   logic              err_reg, err_next;
   logic              err_port_reg, err_port_next;
   logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

   logic [1:0]        req_v, we_v, ok_v, we_m, gnt;
   logic [ADDR_W-1:0] addr_v [2];
   logic [DATA_W-1:0] wdata_v [2];
   logic [ADDR_W-1:0] addr_m [2];
   logic [DATA_W-1:0] wdata_m [2];
   logic              lock_active, starve_sat;

   // Requests are masked while reset is held so nothing is granted or written.
   assign req_v      = {m1_req, m0_req} & {2{rst}};
   assign we_v       = {m1_we, m0_we};
   assign addr_v[0]  = m0_addr;
   assign addr_v[1]  = m1_addr;
   assign wdata_v[0] = m0_wdata;
   assign wdata_v[1] = m1_wdata;

   assign lock_active = (state_reg == LOCK1);
   assign starve_sat  = (starve_cnt_reg == SW'(MAX_WAIT));

   dmem_arb_pick #(
      .CPU_PRIO(CPU_PRIO)
   ) u_pick (
      .req        (req_v),
      .lock_active(lock_active),
      .starve_sat (starve_sat),
      .cpu_first  (cpu_first_reg),
      .last_winner(last_winner_reg),
      .gnt        (gnt)
   );

   // Per-port AND-OR mux legs; the grant is one-hot so OR-ing them is safe.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign ok_v[gi]    = in_range(64'(addr_v[gi]), 64'(DEPTH_WORDS));
         assign addr_m[gi]  = gnt[gi] ? addr_v[gi] : '0;
         assign wdata_m[gi] = gnt[gi] ? wdata_v[gi] : '0;
         assign we_m[gi]    = gnt[gi] & we_v[gi] & ok_v[gi];
      end
   endgenerate

   assign mem_addr  = addr_m[0] | addr_m[1];
   assign mem_wdata = wdata_m[0] | wdata_m[1];
   assign mem_we    = |we_m;

   assign m0_gnt   = gnt[0];
   assign m1_gnt   = gnt[1];
   assign m0_rdata = gnt[0] ? mem_rdata : '0;
   assign m1_rdata = gnt[1] ? mem_rdata : '0;
   assign m0_stall = m0_req & ~gnt[0];

   assign err      = err_reg;
   assign err_port = err_port_reg;
   assign err_addr = err_addr_reg;

   always_comb begin
      state_next       = state_reg;
      lock_cnt_next    = lock_cnt_reg;
      cpu_first_next   = cpu_first_reg;
      last_winner_next = last_winner_reg;
      starve_cnt_next  = '0;
      err_next         = 1'b0;
      err_port_next    = err_port_reg;
      err_addr_next    = err_addr_reg;
      // Number of locked beats including the one granted this cycle.
      beat_cnt = lock_active ? (lock_cnt_reg + LW'(1)) : LW'(1);

      if (|gnt) begin
         last_winner_next = gnt[1];
         cpu_first_next   = 1'b0;
         if ((gnt & ok_v) == 2'b00) begin
            err_next      = 1'b1;
            err_port_next = gnt[1];
            err_addr_next = gnt[1] ? addr_v[1] : addr_v[0];
         end
      end

      if (req_v[1] && !gnt[1]) begin
         starve_cnt_next = starve_sat ? starve_cnt_reg : (starve_cnt_reg + SW'(1));
      end

      if (gnt[1] && m1_lock) begin
         if (beat_cnt >= LW'(LOCK_MAX)) begin
            // Beat limit reached: this beat completes, then the core gets a turn.
            state_next     = IDLE;
            lock_cnt_next  = '0;
            cpu_first_next = 1'b1;
         end else begin
            state_next    = LOCK1;
            lock_cnt_next = beat_cnt;
         end
      end else if (lock_active) begin
         // Request dropped or an unlocked beat was granted: release the lock.
         state_next    = IDLE;
         lock_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         starve_cnt_reg  <= '0;
         lock_cnt_reg    <= '0;
         last_winner_reg <= PORT_DMA;
         cpu_first_reg   <= 1'b0;
         err_reg         <= 1'b0;
         err_port_reg    <= PORT_CPU;
         err_addr_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         starve_cnt_reg  <= starve_cnt_next;
         lock_cnt_reg    <= lock_cnt_next;
         last_winner_reg <= last_winner_next;
         cpu_first_reg   <= cpu_first_next;
         err_reg         <= err_next;
         err_port_reg    <= err_port_next;
         err_addr_reg    <= err_addr_next;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Drives two arbiter instances (k=0: core priority, k=1: pure round-robin)
//   with identical stimulus and compares every output each cycle against a
//   behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int LOCK_MAX = 8;
   localparam int LIMIT    = 4 * 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

   logic [1:0]  o_m0_gnt, o_m1_gnt, o_m0_stall, o_mem_we, o_err, o_err_port;
   logic [31:0] o_m0_rdata [2];
   logic [31:0] o_m1_rdata [2];
   logic [31:0] o_mem_addr [2];
   logic [31:0] o_mem_wdata [2];
   logic [31:0] o_err_addr [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model state per instance.
   int          m_starve [2];
   int          m_beats  [2];
   bit          m_lock   [2];
   bit          m_cpufirst [2];
   bit          m_last   [2];
   bit          m_err    [2];
   bit          m_errport [2];
   logic [31:0] m_erraddr [2];

   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
      .CPU_PRIO(1), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
   ) dut_prio (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(o_m0_gnt[0]), .m0_rdata(o_m0_rdata[0]), .m0_stall(o_m0_stall[0]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(o_m1_gnt[0]), .m1_rdata(o_m1_rdata[0]), .m1_lock(m1_lock),
      .mem_we(o_mem_we[0]), .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]),
      .mem_rdata(mem_rdata),
      .err(o_err[0]), .err_port(o_err_port[0]), .err_addr(o_err_addr[0])
   );

   dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
      .CPU_PRIO(0), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
   ) dut_rr (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(o_m0_gnt[1]), .m0_rdata(o_m0_rdata[1]), .m0_stall(o_m0_stall[1]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(o_m1_gnt[1]), .m1_rdata(o_m1_rdata[1]), .m1_lock(m1_lock),
      .mem_we(o_mem_we[1]), .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]),
      .mem_rdata(mem_rdata),
      .err(o_err[1]), .err_port(o_err_port[1]), .err_addr(o_err_addr[1])
   );

   function automatic void model_reset(input int k);
      m_starve[k]   = 0;
      m_beats[k]    = 0;
      m_lock[k]     = 1'b0;
      m_cpufirst[k] = 1'b0;
      m_last[k]     = 1'b1;
      m_err[k]      = 1'b0;
      m_errport[k]  = 1'b0;
      m_erraddr[k]  = 32'h0;
   endfunction

   // Returns {port1, port0} grant for the current inputs.
   function automatic logic [1:0] model_pick(input int k);
      if (!rst) return 2'b00;
      if (m_lock[k] && m1_req) return 2'b10;
      if (!m0_req && !m1_req) return 2'b00;
      if (m0_req && !m1_req) return 2'b01;
      if (m1_req && !m0_req) return 2'b10;
      if (m_cpufirst[k]) return 2'b01;
      if (k == 0) return (m_starve[k] >= MAX_WAIT) ? 2'b10 : 2'b01;
      return m_last[k] ? 2'b01 : 2'b10;
   endfunction

   function automatic void model_advance(input int k);
      logic [1:0]  g;
      logic [31:0] a;
      bit          exit_max;
      if (!rst) begin
         model_reset(k);
         return;
      end
      g = model_pick(k);
      a = g[1] ? m1_addr : m0_addr;
      m_err[k] = 1'b0;
      if (g != 2'b00) begin
         m_last[k] = g[1];
         if (a >= 32'(LIMIT)) begin
            m_err[k]     = 1'b1;
            m_errport[k] = g[1];
            m_erraddr[k] = a;
         end
      end
      if (m1_req && !g[1]) m_starve[k] = (m_starve[k] + 1 > MAX_WAIT) ? MAX_WAIT : m_starve[k] + 1;
      else                 m_starve[k] = 0;
      exit_max = 1'b0;
      if (g[1] && m1_lock) begin
         m_beats[k] = m_lock[k] ? m_beats[k] + 1 : 1;
         if (m_beats[k] >= LOCK_MAX) begin
            m_lock[k]  = 1'b0;
            m_beats[k] = 0;
            exit_max   = 1'b1;
         end else begin
            m_lock[k] = 1'b1;
         end
      end else begin
         m_lock[k]  = 1'b0;
         m_beats[k] = 0;
      end
      if (exit_max)            m_cpufirst[k] = 1'b1;
      else if (g != 2'b00)     m_cpufirst[k] = 1'b0;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs(input int k);
      logic [1:0]  g;
      logic [31:0] a, d, rd0, rd1;
      logic        w, ok;
      g  = model_pick(k);
      a  = g[1] ? m1_addr : m0_addr;
      d  = g[1] ? m1_wdata : m0_wdata;
      w  = g[1] ? m1_we : m0_we;
      ok = (a < 32'(LIMIT));
      rd0 = g[0] ? mem_rdata : 32'h0;
      rd1 = g[1] ? mem_rdata : 32'h0;
      chk("m0_gnt",    k, 32'(o_m0_gnt[k]),   32'(g[0]));
      chk("m1_gnt",    k, 32'(o_m1_gnt[k]),   32'(g[1]));
      chk("m0_stall",  k, 32'(o_m0_stall[k]), 32'(m0_req & ~g[0]));
      chk("mem_we",    k, 32'(o_mem_we[k]),   32'((g != 2'b00) && w && ok));
      chk("mem_addr",  k, o_mem_addr[k],      (g != 2'b00) ? a : 32'h0);
      chk("mem_wdata", k, o_mem_wdata[k],     (g != 2'b00) ? d : 32'h0);
      if (g == 2'b00 || ok) begin
         chk("m0_rdata", k, o_m0_rdata[k], rd0);
         chk("m1_rdata", k, o_m1_rdata[k], rd1);
      end
      chk("err",       k, 32'(o_err[k]),      32'(m_err[k]));
      chk("err_port",  k, 32'(o_err_port[k]), 32'(m_errport[k]));
      chk("err_addr",  k, o_err_addr[k],      m_erraddr[k]);
   endtask

   // One clock cycle: apply inputs, check at the falling edge, advance the model.
   task automatic step(input logic r,
                       input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk, input logic [31:0] rd);
      rst = r;
      m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      m1_lock = lk; mem_rdata = rd;
      if (!r) begin
         model_reset(0);
         model_reset(1);
      end
      @(negedge clk);
      check_outputs(0);
      check_outputs(1);
      $display("cyc=%0d rst=%b req=%b%b lock=%b gnt_prio=%b%b gnt_rr=%b%b err=%b%b",
               cyc, rst, m1_req, m0_req, m1_lock, o_m1_gnt[0], o_m0_gnt[0],
               o_m1_gnt[1], o_m0_gnt[1], o_err[1], o_err[0]);
      @(posedge clk);
      model_advance(0);
      model_advance(1);
      cyc++;
      #1;
   endtask

   task automatic idle(input logic r);
      step(r, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      logic        q0, q1, w0, w1, lk, r;
      logic [31:0] a0, a1;

      // Reset: no grants, error outputs clear, even with requests present.
      idle(1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b1, 32'h20, 32'h2, 1'b1, 32'h5);
      idle(1'b1);

      // Core read with the memory returning 0xDEADBEEF in the same cycle.
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
      idle(1'b1);

      // Both requesting: starvation guard vs. round-robin alternation.
      for (int i = 0; i < 7; i++)
         step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA5A5_0000 + 32'(i), 1'b0, 32'h1234_5678);
      idle(1'b1);

      // Locked DMA burst against a continuously requesting core.
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hB000 + 32'(i), 1'b1, 32'h0);
      idle(1'b1);

      // Out-of-range core write, then the error pulse and its clearing.
      step(1'b1, 1'b1, 1'b1, 32'h1000, 32'hCAFE, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      idle(1'b1);
      idle(1'b1);

      // Reset in the middle of a lock, then a tie after release.
      for (int i = 0; i < 7; i++)
         step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h200, 32'h77, 1'b1, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h200, 32'h77, 1'b1, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 32'h99);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 63) != 0);
         q0 = ($urandom_range(0, 9) < 7);
         q1 = ($urandom_range(0, 9) < 7);
         w0 = $urandom_range(0, 1) == 1;
         w1 = $urandom_range(0, 1) == 1;
         lk = ($urandom_range(0, 9) < 6);
         a0 = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) * 4
                                          : 32'($urandom_range(0, 1023)) * 4;
         a1 = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) * 4
                                          : 32'($urandom_range(0, 1023)) * 4;
         step(r, q0, w0, a0, $urandom, q1, w1, a1, $urandom, lk, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
